mem_request_arbiter: RTL and testbench
======================================

# mem_request_arbiter

Single-port memory arbiter and sequencer between the CPU's instruction-fetch side and data load/store side and one shared RAM that reports `ram_busy`. It sits between the fetch/PC logic and datapath (`imemaddr`, `dmmaddr`, `dmmstore`) and the RAM. It grants one side at a time, latches address and store data at grant, and waits out the RAM's variable latency. It returns load data with single-cycle `i_ready` / `d_ready` pulses, applies starvation-bounded data priority, and aborts hung RAM transactions via a watchdog.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- `TIMEOUT`, 64: max cycles in a request state before abort; minimum 2.
- `clk` in 1: system clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `i_req` in 1: fetch request, held until `i_ready`.
- `imemaddr` in 32: fetch address.
- `imemload` out 32: fetched instruction, registered.
- `i_ready` out 1: one-cycle fetch-complete pulse.
- `dmm_ren` in 1: data read request, held until `d_ready`.
- `dmm_wen` in 1: data write request, held until `d_ready`.
- `dmmaddr` in 32: data address.
- `dmmstore` in 32: store data.
- `dmmload` out 32: load data, registered.
- `d_ready` out 1: one-cycle data-complete pulse.
- `ramaddr` out 32: RAM address, registered at grant.
- `ramstore` out 32: RAM write data, registered at grant.
- `ramload` in 32: RAM read data, valid when `ram_busy`=0 in a request state.
- `Ren` out 1: RAM read strobe.
- `Wen` out 1: RAM write strobe.
- `ram_busy` in 1: RAM operation in progress.
- `err` out 1: sticky timeout flag.

## Operation
- States: IDLE, IREQ, DREQ, RESP.
- IDLE, data pending (`dmm_ren|dmm_wen`), and not (`i_req` and `starve_cnt`==`STARVE_LIMIT`):
  - Go to DREQ.
  - Latch `dmmaddr` into `ramaddr` and `dmmstore` into `ramstore`.
  - Latch op = write if `dmm_wen`, else read; write wins if both are set.
- Otherwise, IDLE with `i_req`: go to IREQ and latch `imemaddr` into `ramaddr`. Else stay in IDLE.
- `starve_cnt`:
  - Increments (saturating at `STARVE_LIMIT`) on each DREQ grant taken while `i_req`=1.
  - Clears on every IREQ grant.
- Strobes:
  - IREQ: `Ren`=1.
  - DREQ: `Ren`=1 for reads, `Wen`=1 for writes.
  - IDLE and RESP: both 0.
- `wait_cnt` clears on entry to IREQ/DREQ and increments each cycle there.
- Completion: at an edge in IREQ/DREQ with `wait_cnt`>=1 and `ram_busy`=0.
  - DREQ read: `ramload` is captured into `dmmload`.
  - IREQ: `ramload` is captured into `imemload`.
  - DREQ write: `dmmload` is unchanged.
  - Next state is RESP.
- Timeout: at an edge in IREQ/DREQ with `wait_cnt`==`TIMEOUT`-1 and `ram_busy`=1.
  - Capture 0x00000000 into the granted side's load register.
  - Set `err`; go to RESP.
- RESP: pulse the granted side's ready for exactly one cycle, then return to IDLE.
- The requester must deassert or replace its request by the edge ending the ready cycle. Request lines are sampled only in IDLE.
- Request changes during IREQ/DREQ/RESP are ignored. Latched address and data hold until the next grant.
- `err` clears only on reset.
- Asynchronous reset, at any time including mid-transaction:
  - State to IDLE.
  - All outputs, counters and latched registers to 0.
  - The in-flight RAM operation is abandoned with no ready pulse.

## Timing
- Request to ready with zero-wait RAM (`ram_busy` stays 0): 2 cycles.
  - Request sampled at edge 0.
  - Strobe high from edge 0 to edge 2.
  - Ready high from edge 2 to edge 3.
- With `ram_busy` high for N>=1 cycles after the strobe: ready rises at edge 2+N-1, or later if busy persists past `wait_cnt`>=1.
- Back-to-back transactions: one IDLE cycle after RESP. Sustained throughput is one transaction per 4 cycles minimum.
- Fetch with data in flight: the fetch waits in IDLE for RESP to finish, then is granted at the next IDLE edge. Data is granted first on a tie.
- `ramaddr` and `ramstore` are stable for the whole strobe window.
- Load outputs hold their value until the next completion of the same side.

## Test plan
- Reset mid-DREQ write to 0x10, `ram_busy`=1 -> all outputs 0, no `d_ready`, state IDLE next cycle.
- `i_req`, `imemaddr`=0x4, RAM zero-wait, `ramload`=0x00500093 -> `Ren` for 2 cycles; `i_ready` pulses 2 cycles after request with `imemload`=0x00500093.
- `i_req` and `dmm_ren` (addr 0x20) together, `ramload`=0xDEADBEEF -> DREQ first, `d_ready` with `dmmload`=0xDEADBEEF. IREQ is granted on the cycle after return to IDLE.
- `dmm_wen`, `dmmaddr`=0x40, `dmmstore`=0x12345678, `ram_busy` high 3 cycles -> `Wen` high, `ramaddr`=0x40 and `ramstore`=0x12345678 stable until completion; `d_ready` follows busy falling; `dmmload` unchanged.
- `i_req` held while data requests are re-issued each IDLE, `STARVE_LIMIT`=4 -> 4 DREQ grants, then IREQ is granted and `starve_cnt` clears.
- `ram_busy` stuck high, `TIMEOUT`=64 -> ready pulses after 64 cycles in the request state, load register =0, `err`=1 sticky until `nRST`.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// One side is granted at a time, with data priority bounded by a starvation counter and a timeout watchdog.
module mem_request_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        i_req,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        i_ready,
    input  logic        dmm_ren,
    input  logic        dmm_wen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    output logic [31:0] dmmload,
    output logic        d_ready,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    output logic        Ren,
    output logic        Wen,
    input  logic        ram_busy,
    output logic        err
);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1) + 1;

    typedef enum logic [1:0] {IDLE, IREQ, DREQ, RESP} state_t;

    state_t        state_q, state_d;
    logic          side_d_q, side_d_d;   // 1: data side granted
    logic          op_wr_q, op_wr_d;
    logic [31:0]   ramaddr_q, ramaddr_d;
    logic [31:0]   ramstore_q, ramstore_d;
    logic [31:0]   imemload_q, imemload_d;
    logic [31:0]   dmmload_q, dmmload_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    logic data_pend, starve_max;
    assign data_pend  = dmm_ren | dmm_wen;
    assign starve_max = (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        state_d    = state_q;
        side_d_d   = side_d_q;
        op_wr_d    = op_wr_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        imemload_d = imemload_q;
        dmmload_d  = dmmload_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (data_pend && !(i_req && starve_max)) begin
                    state_d    = DREQ;
                    side_d_d   = 1'b1;
                    op_wr_d    = dmm_wen;
                    ramaddr_d  = dmmaddr;
                    ramstore_d = dmmstore;
                    wait_d     = '0;
                    if (i_req && !starve_max) starve_d = starve_q + 1'b1;
                end else if (i_req) begin
                    state_d   = IREQ;
                    side_d_d  = 1'b0;
                    ramaddr_d = imemaddr;
                    wait_d    = '0;
                    starve_d  = '0;
                end
            end
            IREQ, DREQ: begin
                wait_d = wait_q + 1'b1;
                if (!ram_busy && wait_q >= WW'(1)) begin
                    state_d = RESP;
                    if (!side_d_q)     imemload_d = ramload;
                    else if (!op_wr_q) dmmload_d  = ramload;
                end else if (ram_busy && wait_q == WW'(TIMEOUT - 1)) begin
                    // Hung RAM: hand the requester zeros and flag the error.
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (side_d_q) dmmload_d  = '0;
                    else          imemload_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            side_d_q   <= 1'b0;
            op_wr_q    <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            imemload_q <= '0;
            dmmload_q  <= '0;
            starve_q   <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            side_d_q   <= side_d_d;
            op_wr_q    <= op_wr_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            imemload_q <= imemload_d;
            dmmload_q  <= dmmload_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    assign Ren      = (state_q == IREQ) || (state_q == DREQ && !op_wr_q);
    assign Wen      = (state_q == DREQ) && op_wr_q;
    assign i_ready  = (state_q == RESP) && !side_d_q;
    assign d_ready  = (state_q == RESP) && side_d_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign imemload = imemload_q;
    assign dmmload  = dmmload_q;
    assign err      = err_q;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever a ready pulse appears.
module tb_mem_request_arbiter;
    logic        clk = 1'b0;
    logic        nRST;
    logic        i_req, dmm_ren, dmm_wen, ram_busy;
    logic [31:0] imemaddr, dmmaddr, dmmstore, ramload;
    logic [31:0] imemload, dmmload, ramaddr, ramstore;
    logic        i_ready, d_ready, Ren, Wen, err;

    int vec  = 0;
    int miss = 0;

    typedef struct packed {
        logic        d;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_request_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .clk(clk), .nRST(nRST),
        .i_req(i_req), .imemaddr(imemaddr), .imemload(imemload), .i_ready(i_ready),
        .dmm_ren(dmm_ren), .dmm_wen(dmm_wen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .dmmload(dmmload), .d_ready(d_ready),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
        .Ren(Ren), .Wen(Wen), .ram_busy(ram_busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic d, input logic [31:0] data, input logic e);
        exp_t x;
        x.d = d; x.data = data; x.err = e;
        sb.push_back(x);
    endtask

    // Wait (bounded) for any ready pulse; n counts negedges seen.
    task automatic wait_rdy(input logic exp_d, input int maxc, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (i_ready || d_ready) break;
            if (n >= maxc) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        chk("ready_side", {31'd0, d_ready}, {31'd0, exp_d});
    endtask

    always @(negedge clk) begin
        if (nRST && (i_ready || d_ready)) begin
            exp_t x;
            chk("one_ready", {31'd0, i_ready & d_ready}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("resp_side", {31'd0, d_ready}, {31'd0, x.d});
                chk("resp_data", x.d ? dmmload : imemload, x.data);
                chk("resp_err", {31'd0, err}, {31'd0, x.err});
            end
        end
    end

    initial begin
        int n;
        logic [31:0] vals [0:5];
        nRST = 1'b0; i_req = 0; dmm_ren = 0; dmm_wen = 0; ram_busy = 0;
        imemaddr = 0; dmmaddr = 0; dmmstore = 0; ramload = 0;
        #3;
        chk("rst_ren", {31'd0, Ren}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);

        // Zero-wait fetch
        i_req = 1; imemaddr = 32'h4; ramload = 32'h00500093;
        push(1'b0, 32'h00500093, 1'b0);
        @(negedge clk);
        chk("f_ren0", {31'd0, Ren}, 32'd1);
        chk("f_addr", ramaddr, 32'h4);
        chk("f_rdy0", {31'd0, i_ready}, 32'd0);
        @(negedge clk);
        chk("f_ren1", {31'd0, Ren}, 32'd1);
        chk("f_rdy1", {31'd0, i_ready}, 32'd0);
        @(negedge clk);
        chk("f_rdy2", {31'd0, i_ready}, 32'd1);
        chk("f_ren2", {31'd0, Ren}, 32'd0);
        i_req = 0;
        @(negedge clk);

        // Tie: data first, then fetch after one IDLE cycle
        i_req = 1; imemaddr = 32'h8; dmm_ren = 1; dmmaddr = 32'h20; ramload = 32'hDEADBEEF;
        push(1'b1, 32'hDEADBEEF, 1'b0);
        push(1'b0, 32'h11112222, 1'b0);
        @(negedge clk);
        chk("t_ren", {31'd0, Ren}, 32'd1);
        chk("t_wen", {31'd0, Wen}, 32'd0);
        chk("t_addr", ramaddr, 32'h20);
        wait_rdy(1'b1, 20, n);
        chk("t_dlat", n, 32'd2);
        dmm_ren = 0; ramload = 32'h11112222;
        @(negedge clk);
        chk("t_idle", {31'd0, Ren}, 32'd0);
        @(negedge clk);
        chk("t_iren", {31'd0, Ren}, 32'd1);
        chk("t_iaddr", ramaddr, 32'h8);
        wait_rdy(1'b0, 20, n);
        chk("t_ilat", n, 32'd2);
        i_req = 0;
        @(negedge clk);

        // Write with 3 busy cycles; latched address/data must hold
        dmm_wen = 1; dmmaddr = 32'h40; dmmstore = 32'h12345678; ram_busy = 1;
        push(1'b1, 32'hDEADBEEF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w_wen", {31'd0, Wen}, 32'd1);
            chk("w_ren", {31'd0, Ren}, 32'd0);
            chk("w_addr", ramaddr, 32'h40);
            chk("w_store", ramstore, 32'h12345678);
            chk("w_rdy", {31'd0, d_ready}, 32'd0);
            if (k == 0) begin dmmaddr = 32'h99; dmmstore = 32'h0; end
            if (k == 3) ram_busy = 0;
        end
        wait_rdy(1'b1, 20, n);
        chk("w_lat", n, 32'd1);
        dmm_wen = 0;
        @(negedge clk);

        // Starvation: four data grants, then the fetch is forced
        for (int k = 0; k < 6; k++) vals[k] = 32'hA0000000 + k;
        i_req = 1; imemaddr = 32'hC; dmm_ren = 1; dmmaddr = 32'h80; ramload = vals[0];
        for (int k = 0; k < 6; k++) push(k != 4, vals[k], 1'b0);
        for (int k = 0; k < 6; k++) begin
            wait_rdy(k != 4, 20, n);
            if (k < 5) ramload = vals[k + 1];
            if (k == 4) i_req = 0;
            if (k == 5) dmm_ren = 0;
        end
        @(negedge clk);

        // Watchdog: busy stuck high
        dmm_ren = 1; dmmaddr = 32'h100; ram_busy = 1; ramload = 32'hFFFFFFFF;
        push(1'b1, 32'h0, 1'b1);
        wait_rdy(1'b1, 100, n);
        chk("to_lat", n, 32'd65);
        dmm_ren = 0; ram_busy = 0;
        repeat (5) @(negedge clk);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-write
        dmm_wen = 1; dmmaddr = 32'h10; dmmstore = 32'h55; ram_busy = 1;
        @(negedge clk);
        @(negedge clk);
        chk("r_wen", {31'd0, Wen}, 32'd1);
        chk("r_addr", ramaddr, 32'h10);
        nRST = 1'b0;
        #1;
        chk("r_wen0", {31'd0, Wen}, 32'd0);
        chk("r_ren0", {31'd0, Ren}, 32'd0);
        chk("r_addr0", ramaddr, 32'd0);
        chk("r_store0", ramstore, 32'd0);
        chk("r_iload0", imemload, 32'd0);
        chk("r_dload0", dmmload, 32'd0);
        chk("r_err0", {31'd0, err}, 32'd0);
        chk("r_rdy0", {31'd0, i_ready | d_ready}, 32'd0);
        dmm_wen = 0; ram_busy = 0;
        @(negedge clk);
        nRST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("r_quiet", {30'd0, Ren | Wen, i_ready | d_ready}, 32'd0);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
